// File: rtl/soc_sram_sp_master_pkg.sv
// ----------------------------------------------------------------------------
// soc_optimsoc_functions
//   Shared definitions for the single-port SRAM initiator:
//     clog2          - ceiling log2, used for SW/WORD_AW and counter widths
//     rsp_entry_t    - response FIFO entry {err, rdata}
//     RSP_FIFO_DEPTH - response FIFO depth, also the outstanding-request limit
//     state_t        - controller states
// ----------------------------------------------------------------------------
package soc_optimsoc_functions;

    localparam int RSP_FIFO_DEPTH = 3;

    // A package cannot take parameters, so rdata is sized for the widest
    // supported XLEN; narrower instances use the low XLEN bits only.
    localparam int MAX_XLEN = 32;

    typedef struct packed {
        logic                err;
        logic [MAX_XLEN-1:0] rdata;
    } rsp_entry_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/soc_sram_sp_master_if.sv
// ----------------------------------------------------------------------------
// soc_sram_sp_master_if
//   Request/response handshake between a bus adapter / DMA (master modport)
//   and the SRAM initiator (slave modport).
//     req_valid/req_ready  request handshake; req_we, req_addr, req_wdata,
//                          req_sel carry the request
//     rsp_valid/rsp_ready  response handshake; rsp_rdata, rsp_err carry it
// ----------------------------------------------------------------------------
interface soc_sram_sp_master_if #(
    parameter int PLEN = 32,
    parameter int XLEN = 32
);
    localparam int SW = XLEN / 8;

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [PLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [SW-1:0]   req_sel;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/soc_sram_sp_rsp_fifo.sv
// ----------------------------------------------------------------------------
// soc_sram_sp_rsp_fifo
//   Small synchronous FIFO holding in-order responses.
//     clk, rst  clock, asynchronous active-high reset (empties the FIFO)
//     push/din  write one entry (caller guarantees not full)
//     pop/dout  dout is the head entry; pop removes it (caller guarantees
//               not empty)
//     count     number of stored entries
// ----------------------------------------------------------------------------
module soc_sram_sp_rsp_fifo
    import soc_optimsoc_functions::*;
#(
    parameter  int DEPTH = RSP_FIFO_DEPTH,
    localparam int CW    = clog2(DEPTH + 1),
    localparam int PW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  rsp_entry_t    din,
    input  logic          pop,
    output rsp_entry_t    dout,
    output logic [CW-1:0] count
);

    rsp_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/soc_sram_sp_master.sv
// ----------------------------------------------------------------------------
// soc_sram_sp_master
//   Initiator for a single-port SRAM with one-cycle registered read data.
//   Accepts byte-addressed requests, range-checks them against MEM_SIZE_BYTE,
//   issues at most one SRAM access per cycle and returns one in-order
//   response per request through a 3-entry response FIFO.
//
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     bus (slave)       request/response handshake
//     init_done         memory usable (controller in RUN)
//     sram_ce/we/oe     SRAM controls
//     sram_waddr        word address
//     sram_din/sel      write data / byte selects
//     sram_dout         SRAM read data, valid the cycle after the access
//
//   Build option SRAM_INIT_CLEAR_EN: after reset the controller sweeps the
//   whole memory writing zeros (one word per cycle) before accepting
//   requests. Without it the controller is in RUN straight out of reset and
//   the memory keeps its preload contents.
// ----------------------------------------------------------------------------
module soc_sram_sp_master
    import soc_optimsoc_functions::*;
#(
    parameter  int PLEN           = 32,
    parameter  int XLEN           = 32,
    // Must be overridden with the real memory size (multiple of SW).
    parameter  int MEM_SIZE_BYTE  = 'h400,
    localparam int SW             = XLEN / 8,
    localparam int LSB            = clog2(SW),
    localparam int WORD_AW        = PLEN - LSB,
    localparam int MEM_SIZE_WORDS = MEM_SIZE_BYTE / SW,
    localparam int CW             = clog2(RSP_FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    soc_sram_sp_master_if.slave bus,
    output logic                init_done,
    output logic                sram_ce,
    output logic                sram_we,
    output logic                sram_oe,
    output logic [WORD_AW-1:0]  sram_waddr,
    output logic [XLEN-1:0]     sram_din,
    output logic [SW-1:0]       sram_sel,
    input  logic [XLEN-1:0]     sram_dout
);

    localparam logic [PLEN:0] MEM_LIMIT = (PLEN + 1)'(MEM_SIZE_BYTE);

    state_t             state;
    logic               sweep;
    logic [WORD_AW-1:0] sweep_addr;

`ifdef SRAM_INIT_CLEAR_EN
    localparam logic [WORD_AW-1:0] LAST_WORD = WORD_AW'(MEM_SIZE_WORDS - 1);

    state_t             state_nxt;
    logic [WORD_AW-1:0] wcnt;
    logic [WORD_AW-1:0] wcnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        if (state == ST_INIT) begin
            wcnt_nxt = wcnt + 1'b1;
            if (wcnt == LAST_WORD) state_nxt = ST_RUN;
        end
    end

    // Gated by rst so the SRAM port stays quiet while reset is held.
    assign sweep      = (state == ST_INIT) && !rst;
    assign sweep_addr = wcnt;
`else
    assign state      = ST_RUN;
    assign sweep      = 1'b0;
    assign sweep_addr = '0;
`endif

    // ---------------------------------------------------------------- accept
    logic          req_ready;
    logic          accept;
    logic          in_range;
    logic          infl_vld;
    logic          infl_we;
    logic          infl_err;
    logic [CW-1:0] fifo_cnt;
    rsp_entry_t    push_e;
    rsp_entry_t    head;
    logic          rsp_valid;
    logic          pop;

    // Stored responses plus the one in flight must fit in the FIFO.
    assign req_ready = (state == ST_RUN) &&
                       ((int'(fifo_cnt) + int'(infl_vld)) < RSP_FIFO_DEPTH);
    assign accept    = bus.req_valid && req_ready;
    assign in_range  = {1'b0, bus.req_addr} < MEM_LIMIT;

    assign bus.req_ready = req_ready;
    assign init_done     = (state == ST_RUN);

    // ------------------------------------------------------------- SRAM port
    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_oe    = 1'b0;
        sram_waddr = bus.req_addr[PLEN-1:LSB];
        sram_din   = bus.req_wdata;
        sram_sel   = '0;
        if (sweep) begin
            sram_ce    = 1'b1;
            sram_we    = 1'b1;
            sram_waddr = sweep_addr;
            sram_din   = '0;
            sram_sel   = '1;
        end else if (accept && in_range) begin
            sram_ce  = 1'b1;
            sram_we  = bus.req_we;
            sram_oe  = !bus.req_we;
            sram_sel = bus.req_sel;
        end
    end

    // -------------------------------------------------------------- inflight
    // Tags of the access issued last cycle; its read data arrives now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infl_vld <= 1'b0;
            infl_we  <= 1'b0;
            infl_err <= 1'b0;
        end else begin
            infl_vld <= accept;
            if (accept) begin
                infl_we  <= bus.req_we;
                infl_err <= !in_range;
            end
        end
    end

    always_comb begin
        push_e       = '0;
        push_e.err   = infl_err;
        if (!infl_we && !infl_err) push_e.rdata = MAX_XLEN'(sram_dout);
    end

    // -------------------------------------------------------------- response
    assign rsp_valid = (fifo_cnt != '0);
    assign pop       = rsp_valid && bus.rsp_ready;

    soc_sram_sp_rsp_fifo #(.DEPTH(RSP_FIFO_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (infl_vld),
        .din   (push_e),
        .pop   (pop),
        .dout  (head),
        .count (fifo_cnt)
    );

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_valid ? head.rdata[XLEN-1:0] : '0;
    assign bus.rsp_err   = rsp_valid && head.err;

endmodule

// File: tb/tb_soc_sram_sp_master.sv
// ----------------------------------------------------------------------------
// tb_soc_sram_sp_master
//   Bench for soc_sram_sp_master (PLEN=32, XLEN=32, MEM_SIZE_BYTE=64) with a
//   behavioural SRAM, a word-array reference memory and an expected-response
//   queue. Honours SRAM_INIT_CLEAR_EN when defined.
// ----------------------------------------------------------------------------
module tb_soc_sram_sp_master;
    localparam int PLEN  = 32;
    localparam int XLEN  = 32;
    localparam int MEMB  = 64;
    localparam int WORDS = MEMB / 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done, sram_ce, sram_we, sram_oe;
    logic [29:0] sram_waddr;
    logic [31:0] sram_din, sram_dout;
    logic [3:0]  sram_sel;

    always #5 clk = ~clk;

    soc_sram_sp_master_if #(.PLEN(PLEN), .XLEN(XLEN)) bus ();

    soc_sram_sp_master #(.PLEN(PLEN), .XLEN(XLEN), .MEM_SIZE_BYTE(MEMB)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .init_done  (init_done),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_oe    (sram_oe),
        .sram_waddr (sram_waddr),
        .sram_din   (sram_din),
        .sram_sel   (sram_sel),
        .sram_dout  (sram_dout)
    );

    // Behavioural single-port SRAM, registered read data.
    logic [31:0] smem [WORDS];
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_sel[b]) smem[sram_waddr[3:0]][8*b +: 8] <= sram_din[8*b +: 8];
            end else if (sram_oe) begin
                sram_dout <= smem[sram_waddr[3:0]];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic [31:0] ref_mem [WORDS];
    exp_t        expq [$];
    int          rsp_cyc [$];
    int          last_acc;
    bit          rnd_rsp = 0;
    exp_t        e;

    function automatic void model(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] sel);
        exp_t x;
        int   w;
        x.rdata = '0;
        x.err   = 1'b0;
        if (addr >= MEMB) begin
            x.err = 1'b1;
        end else begin
            w = int'(addr) / 4;
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                x.rdata = ref_mem[w];
            end
        end
        expq.push_back(x);
    endfunction

    // Response monitor: every handshake is compared against the model.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            rsp_cyc.push_back(cyc);
            chk("rsp_expected", 64'(expq.size() != 0), 64'd1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk("rsp_err", bus.rsp_err, e.err);
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] sel, output int waits);
        bit done;
        bit inr;
        done          = 0;
        waits         = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_sel   = sel;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                inr = (addr < MEMB);
                chk("sram_ce", sram_ce, inr);
                chk("sram_we", sram_we, inr & we);
                chk("sram_oe", sram_oe, inr & !we);
                if (inr) begin
                    chk("sram_waddr", sram_waddr, addr >> 2);
                    chk("sram_sel", sram_sel, sel);
                    if (we) chk("sram_din", sram_din, wdata);
                end
                model(we, addr, wdata, sel);
                last_acc = cyc;
                done     = 1;
            end else begin
                waits++;
                if (init_done) chk("sram_ce_idle", sram_ce, 0);
            end
            @(posedge clk);
            #1;
            if (rnd_rsp) bus.rsp_ready = 1'($urandom_range(0, 1));
        end
        chk("req_accepted", done, 1);
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 64 && expq.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain_empty", expq.size(), 0);
        chk("drain_rsp_valid", bus.rsp_valid, 0);
    endtask

`ifdef SRAM_INIT_CLEAR_EN
    task automatic check_sweep();
        for (int i = 0; i < WORDS; i++) begin
            @(negedge clk);
            chk("init_ce", sram_ce, 1);
            chk("init_we", sram_we, 1);
            chk("init_oe", sram_oe, 0);
            chk("init_waddr", sram_waddr, i);
            chk("init_sel", sram_sel, 4'hf);
            chk("init_din", sram_din, 0);
            chk("init_req_ready", bus.req_ready, 0);
            chk("init_done_lo", init_done, 0);
        end
        @(negedge clk);
        chk("init_done_hi", init_done, 1);
        chk("run_req_ready", bus.req_ready, 1);
        for (int w = 0; w < WORDS; w++) ref_mem[w] = '0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          wa, wb, wc;
        int          a0, a1;
        logic [31:0] v, ra;

        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0;
        bus.req_wdata = 0; bus.req_sel = 0; bus.rsp_ready = 0;
        for (int w = 0; w < WORDS; w++) begin
            v          = (w == 4) ? 32'h0 : $urandom;
            smem[w]    <= v;
            ref_mem[w] = v;
        end

        // Reset state
        @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_sram_ce", sram_ce, 0);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_sram_oe", sram_oe, 0);
`ifdef SRAM_INIT_CLEAR_EN
        chk("rst_init_done", init_done, 0);
        chk("rst_req_ready", bus.req_ready, 0);
`else
        chk("rst_init_done", init_done, 1);
        chk("rst_req_ready", bus.req_ready, 1);
`endif
        @(posedge clk); #1; rst = 1'b0;
`ifdef SRAM_INIT_CLEAR_EN
        check_sweep();
`else
        @(negedge clk);
        chk("run_init_done", init_done, 1);
        chk("run_req_ready", bus.req_ready, 1);
`endif
        @(posedge clk); #1;

        // Last word, partial and full writes, read-back in order
        bus.rsp_ready = 1'b1;
        do_req(0, 32'h3C, 0, 4'hf, wa);
        do_req(1, 32'h10, 32'hDEADBEEF, 4'b0101, wa);
        do_req(1, 32'h20, 32'h11223344, 4'b1111, wa);
        do_req(0, 32'h20, 0, 4'hf, wa);
        do_req(0, 32'h10, 0, 4'hf, wa);
        do_req(1, 32'h14, 32'h55667788, 4'b0000, wa);
        do_req(0, 32'h14, 0, 4'hf, wa);
        idle();
        drain();
        chk("partial_write_word", ref_mem[4], 32'h00AD00EF);

        // Back-to-back reads: no stall, responses at N+2, N+3, N+4
        rsp_cyc.delete();
        do_req(0, 32'h0, 0, 4'hf, wa); a0 = last_acc;
        do_req(0, 32'h4, 0, 4'hf, wb); a1 = last_acc;
        do_req(0, 32'h8, 0, 4'hf, wc);
        idle();
        drain();
        chk("b2b_no_wait", wa + wb + wc, 0);
        chk("b2b_consecutive", a1, a0 + 1);
        chk("b2b_rsp_count", rsp_cyc.size(), 3);
        if (rsp_cyc.size() == 3) begin
            chk("b2b_rsp0_cycle", rsp_cyc[0], a0 + 2);
            chk("b2b_rsp1_cycle", rsp_cyc[1], a0 + 3);
            chk("b2b_rsp2_cycle", rsp_cyc[2], a0 + 4);
        end

        // Backpressure: three outstanding, fourth stalls until drained
        bus.rsp_ready = 1'b0;
        do_req(0, 32'h20, 0, 4'hf, wa);
        do_req(0, 32'h24, 0, 4'hf, wa);
        do_req(0, 32'h28, 0, 4'hf, wa);
        bus.req_addr = 32'h2C;
        bus.req_we   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_req_ready", bus.req_ready, 0);
            chk("bp_rsp_valid", bus.rsp_valid, 1);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        do_req(0, 32'h2C, 0, 4'hf, wa);
        chk("bp_fourth_waited", 64'(wa > 0), 64'd1);
        idle();
        drain();

        // Out of range: no SRAM access, error response
        do_req(0, 32'h40, 0, 4'hf, wa);
        do_req(1, 32'h44, 32'hCAFEF00D, 4'hf, wa);
        do_req(0, 32'h3C, 0, 4'hf, wa);
        idle();
        drain();

        // Randomized traffic with random response backpressure
        rnd_rsp = 1;
        for (int n = 0; n < 150; n++) begin
            ra = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)), wa);
        end
        idle();
        rnd_rsp = 0;
        drain();

        // Reset with two responses pending
        bus.rsp_ready = 1'b0;
        do_req(0, 32'h0, 0, 4'hf, wa);
        do_req(0, 32'h4, 0, 4'hf, wa);
        idle();
        repeat (2) @(negedge clk);
        chk("pre_rst_rsp_valid", bus.rsp_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        chk("mid_rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("mid_rst_sram_ce", sram_ce, 0);
        expq.delete();
        @(posedge clk); #1; rst = 1'b0;
`ifdef SRAM_INIT_CLEAR_EN
        check_sweep();
`else
        @(negedge clk);
        chk("rerun_init_done", init_done, 1);
`endif
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        for (int w = 0; w < WORDS; w += 3) do_req(0, 32'(w * 4), 0, 4'hf, wa);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
